// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, control-unit states, ALU ops and instruction fields.
// Used by control_unit, register_file and the ALU.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ADDI = 3'b010,
    OP_LW   = 3'b011,
    OP_SW   = 3'b100,
    OP_BEQ  = 3'b101,
    OP_J    = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01
  } alu_op_e;

  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 5;
  localparam int RD_BIT   = 4;
  localparam int RS_BIT   = 3;
  localparam int IMM_MSB  = 2;
  localparam int IMM_LSB  = 0;
  localparam int JOFF_MSB = 4;

  typedef struct packed {
    logic instr_req;
    logic imm_sel;
    logic reg_sel;
    logic mem_read;
    logic mem_write;
    logic halted;
  } cu_ctl_t;

  // Moore control word for the state being entered; outputs are registered from this.
  function automatic cu_ctl_t ctl_of(state_e s, opcode_e op);
    cu_ctl_t c;
    c = '0;
    case (s)
      S_FETCH: c.instr_req = 1'b1;
      S_EXEC:  c.imm_sel   = (op == OP_ADDI);
      S_MEM: begin
        c.mem_read  = (op == OP_LW);
        c.mem_write = (op == OP_SW);
      end
      S_WB: begin
        c.reg_sel = 1'b1;
        c.imm_sel = (op == OP_ADDI);
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cu_next_pc.sv
// Next-PC arithmetic: PC+1, conditional-branch target (sext imm3) and jump target (sext IR[4:0]).
// All results wrap modulo 2**PC_WIDTH.
module cu_next_pc #(
  parameter int PC_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [4:0]          offset,
  output logic [PC_WIDTH-1:0] pc_inc,
  output logic [PC_WIDTH-1:0] pc_branch,
  output logic [PC_WIDTH-1:0] pc_jump
);

  assign pc_inc    = pc + PC_WIDTH'(1);
  assign pc_branch = pc_inc + {{(PC_WIDTH-3){offset[2]}}, offset[2:0]};
  assign pc_jump   = pc_inc + {{(PC_WIDTH-5){offset[4]}}, offset};

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit CPU, driving register_file, ALU and data memory.
// Define CU_PERF_CNT_EN to add the saturating retired_cnt output.
//
// state  | meaning
// FETCH  | instr_req high, wait for instr_valid, capture IR
// DECODE | one cycle, IR fields presented to register_file
// EXEC   | ALU cycle; BEQ/J update pc and return to FETCH
// MEM    | memRead/memWrite held until mem_ready
// WB     | regSelect for one cycle, pc+1
// HALT   | core stopped, leave only through RST
module control_unit #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   instr_req,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic                   mem_ready,
  input  logic                   zero,
  output logic                   rd,
  output logic                   rs,
  output logic [2:0]             imm,
  output logic                   immSelect,
  output logic                   regSelect,
  output logic [1:0]             aluOp,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   halted
`ifdef CU_PERF_CNT_EN
  ,
  output logic [15:0]            retired_cnt
`endif
);
  import cpu_pkg::*;

  state_e               state;
  logic [INSTR_WIDTH-1:0] ir;
  cu_ctl_t              ctl;
  opcode_e              op;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic [PC_WIDTH-1:0]  pc_branch;
  logic [PC_WIDTH-1:0]  pc_jump;

  assign op = opcode_e'(ir[OP_MSB:OP_LSB]);

  cu_next_pc #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
    .pc        (pc),
    .offset    (ir[JOFF_MSB:0]),
    .pc_inc    (pc_inc),
    .pc_branch (pc_branch),
    .pc_jump   (pc_jump)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_FETCH;
      ir    <= '0;
      pc    <= RESET_PC;
      ctl   <= ctl_of(S_FETCH, OP_ADD);
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_DECODE;
            ctl   <= ctl_of(S_DECODE, op);
          end
        end
        S_DECODE: begin
          state <= S_EXEC;
          ctl   <= ctl_of(S_EXEC, op);
        end
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_ADDI: begin
              state <= S_WB;
              ctl   <= ctl_of(S_WB, op);
            end
            OP_LW, OP_SW: begin
              state <= S_MEM;
              ctl   <= ctl_of(S_MEM, op);
            end
            OP_BEQ: begin
              pc    <= zero ? pc_branch : pc_inc;
              state <= S_FETCH;
              ctl   <= ctl_of(S_FETCH, op);
            end
            OP_J: begin
              pc    <= pc_jump;
              state <= S_FETCH;
              ctl   <= ctl_of(S_FETCH, op);
            end
            default: begin
              state <= S_HALT;
              ctl   <= ctl_of(S_HALT, op);
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_LW) begin
              state <= S_WB;
              ctl   <= ctl_of(S_WB, op);
            end else begin
              pc    <= pc_inc;
              state <= S_FETCH;
              ctl   <= ctl_of(S_FETCH, op);
            end
          end
        end
        S_WB: begin
          pc    <= pc_inc;
          state <= S_FETCH;
          ctl   <= ctl_of(S_FETCH, op);
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
          ctl   <= ctl_of(S_FETCH, op);
        end
      endcase
    end
  end

  assign instr_req = ctl.instr_req;
  assign immSelect = ctl.imm_sel;
  assign regSelect = ctl.reg_sel;
  assign memRead   = ctl.mem_read;
  assign memWrite  = ctl.mem_write;
  assign halted    = ctl.halted;
  assign rd        = ir[RD_BIT];
  assign rs        = ir[RS_BIT];
  assign imm       = ir[IMM_MSB:IMM_LSB];
  assign aluOp     = (op == OP_SUB || op == OP_BEQ) ? ALU_SUB : ALU_ADD;

`ifdef CU_PERF_CNT_EN
  // An instruction retires on the cycle it leaves its last state; HALT never retires.
  logic retire;
  assign retire = (state == S_EXEC && (op == OP_BEQ || op == OP_J))
               || (state == S_MEM && mem_ready && op == OP_SW)
               || (state == S_WB);

  always_ff @(posedge CLK) begin
    if (RST) begin
      retired_cnt <= '0;
    end else if (retire && retired_cnt != 16'hFFFF) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, reset/halt sequences and
// randomized instructions checked against an instruction-level model.
module tb_control_unit;

  logic       CLK;
  logic       RST;
  logic       instr_req;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] pc;
  logic       mem_ready;
  logic       zero;
  logic       rd;
  logic       rs;
  logic [2:0] imm;
  logic       immSelect;
  logic       regSelect;
  logic [1:0] aluOp;
  logic       memRead;
  logic       memWrite;
  logic       halted;
`ifdef CU_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  int n_checks;
  int n_errors;
  int m_pc;
  int m_ret;

  control_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .instr_req   (instr_req),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .mem_ready   (mem_ready),
    .zero        (zero),
    .rd          (rd),
    .rs          (rs),
    .imm         (imm),
    .immSelect   (immSelect),
    .regSelect   (regSelect),
    .aluOp       (aluOp),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .halted      (halted)
`ifdef CU_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] ins;
    logic       z;
    int         w;
    int         e_pc;
    int         e_cyc;
    int         e_reg;
    int         e_mr;
    int         e_mw;
    int         e_imm;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    m_pc = 0;
    m_ret = 0;
  endtask

  // Issues one instruction from FETCH and observes until FETCH or HALT is reached again.
  task automatic run_instr(input logic [7:0] ins, input logic z, input int w,
                           output int cyc, output int n_reg, output int n_mr,
                           output int n_mw, output int n_imm, output int bad);
    int  mem_seen;
    int  op;
    int  exp_alu;
    bit  done;
    cyc = 0; n_reg = 0; n_mr = 0; n_mw = 0; n_imm = 0; bad = 0;
    mem_seen = 0; done = 0;
    op = int'(ins[7:5]);
    exp_alu = (op == 1 || op == 5) ? 1 : 0;
    instr = ins;
    instr_valid = 1'b1;
    zero = z;
    mem_ready = 1'b0;
    while (!done) begin
      @(negedge CLK);
      cyc++;
      instr_valid = 1'b0;
      mem_ready = 1'b0;
      if (instr_req || halted) begin
        done = 1;
      end else begin
        if (regSelect) n_reg++;
        if (memRead)   n_mr++;
        if (memWrite)  n_mw++;
        if (immSelect) n_imm++;
        if (rd !== ins[4] || rs !== ins[3] || imm !== ins[2:0] || int'(aluOp) != exp_alu) bad++;
        if (int'(regSelect) + int'(memRead) + int'(memWrite) > 1) bad++;
        if (memRead || memWrite) begin
          mem_seen++;
          mem_ready = (mem_seen >= w);
        end
        // junk fetch responses outside FETCH must be ignored
        instr = 8'($urandom);
        instr_valid = 1'($urandom);
        if (cyc >= 60) begin
          done = 1;
          n_checks++;
          n_errors++;
          $display("FAIL timeout: instr %h did not return to FETCH within %0d cycles", ins, cyc);
        end
      end
    end
    instr_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic exec_and_check(input string tag, input logic [7:0] ins, input logic z,
                                input int w, input int e_pc, input int e_cyc, input int e_reg,
                                input int e_mr, input int e_mw, input int e_imm, input int e_halt);
    int cyc, n_reg, n_mr, n_mw, n_imm, bad;
    run_instr(ins, z, w, cyc, n_reg, n_mr, n_mw, n_imm, bad);
    check({tag, " cycles"}, cyc, e_cyc);
    check({tag, " pc"}, int'(pc), e_pc);
    check({tag, " regSelect_cycles"}, n_reg, e_reg);
    check({tag, " memRead_cycles"}, n_mr, e_mr);
    check({tag, " memWrite_cycles"}, n_mw, e_mw);
    check({tag, " immSelect_cycles"}, n_imm, e_imm);
    check({tag, " fields_aluop_exclusive"}, bad, 0);
    check({tag, " halted"}, int'(halted), e_halt);
    if (e_halt == 0) m_ret++;
`ifdef CU_PERF_CNT_EN
    check({tag, " retired_cnt"}, int'(retired_cnt), m_ret);
`endif
    m_pc = e_pc;
  endtask

  initial begin
    int pc_hold;
    n_checks = 0;
    n_errors = 0;
    RST = 1'b1;
    instr_valid = 1'b0;
    instr = 8'h00;
    mem_ready = 1'b0;
    zero = 1'b0;

    tbl[0]  = '{8'h4C, 1'b0, 1, 8'h01, 4, 1, 0, 0, 2};
    tbl[1]  = '{8'h68, 1'b0, 3, 8'h02, 7, 1, 3, 0, 0};
    tbl[2]  = '{8'h90, 1'b0, 1, 8'h03, 4, 0, 0, 1, 0};
    tbl[3]  = '{8'h1B, 1'b0, 1, 8'h04, 4, 1, 0, 0, 0};
    tbl[4]  = '{8'h35, 1'b0, 1, 8'h05, 4, 1, 0, 0, 0};
    tbl[5]  = '{8'hA6, 1'b1, 1, 8'h04, 3, 0, 0, 0, 0};
    tbl[6]  = '{8'h00, 1'b0, 1, 8'h05, 4, 1, 0, 0, 0};
    tbl[7]  = '{8'hA6, 1'b0, 1, 8'h06, 3, 0, 0, 0, 0};
    tbl[8]  = '{8'hC3, 1'b0, 1, 8'h0A, 3, 0, 0, 0, 0};
    tbl[9]  = '{8'h9F, 1'b0, 2, 8'h0B, 5, 0, 0, 2, 0};
    tbl[10] = '{8'hDE, 1'b0, 1, 8'h0A, 3, 0, 0, 0, 0};
    tbl[11] = '{8'hD4, 1'b0, 1, 8'hFF, 3, 0, 0, 0, 0};
    tbl[12] = '{8'h00, 1'b0, 1, 8'h00, 4, 1, 0, 0, 0};
    tbl[13] = '{8'hA4, 1'b1, 1, 8'hFD, 3, 0, 0, 0, 0};
    tbl[14] = '{8'h4F, 1'b0, 1, 8'hFE, 4, 1, 0, 0, 2};

    // reset state
    do_reset();
    check("reset pc", int'(pc), 0);
    check("reset outputs", int'({instr_req, regSelect, memRead, memWrite, halted, immSelect}), 32);
`ifdef CU_PERF_CNT_EN
    check("reset retired_cnt", int'(retired_cnt), 0);
`endif

    // move pc away from zero, then reset in the middle of a stalled LW
    exec_and_check("pre_j", 8'hC3, 1'b0, 1, 4, 3, 0, 0, 0, 0, 0);
    instr = 8'h68;
    instr_valid = 1'b1;
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      instr_valid = 1'b0;
    end
    check("midmem memRead", int'(memRead), 1);
    @(negedge CLK);
    check("midmem memRead held", int'(memRead), 1);
    RST = 1'b1;
    @(negedge CLK);
    check("midmem rst memRead", int'(memRead), 0);
    check("midmem rst pc", int'(pc), 0);
    @(negedge CLK);
    RST = 1'b0;
    m_pc = 0;
    m_ret = 0;
    check("midmem rst fetch", int'(instr_req), 1);
`ifdef CU_PERF_CNT_EN
    check("midmem rst retired_cnt", int'(retired_cnt), 0);
`endif

    // directed vectors, starting from pc 0
    for (int i = 0; i < 15; i++) begin
      exec_and_check($sformatf("vec%0d", i), tbl[i].ins, tbl[i].z, tbl[i].w, tbl[i].e_pc,
                     tbl[i].e_cyc, tbl[i].e_reg, tbl[i].e_mr, tbl[i].e_mw, tbl[i].e_imm, 0);
    end

    // HALT stays stopped with pc frozen while fetch responses keep arriving
    exec_and_check("halt", 8'hE0, 1'b0, 1, m_pc, 3, 0, 0, 0, 0, 1);
    pc_hold = int'(pc);
    for (int i = 0; i < 10; i++) begin
      instr = 8'($urandom);
      instr_valid = 1'($urandom);
      mem_ready = 1'($urandom);
      @(negedge CLK);
      check($sformatf("halt_hold%0d outputs", i),
            int'({halted, instr_req, regSelect, memRead, memWrite}), 16);
      check($sformatf("halt_hold%0d pc", i), int'(pc), pc_hold);
`ifdef CU_PERF_CNT_EN
      check($sformatf("halt_hold%0d retired_cnt", i), int'(retired_cnt), m_ret);
`endif
    end
    do_reset();
    check("post_halt fetch", int'({instr_req, halted}), 2);

    // randomized program against the instruction-level model
    for (int k = 0; k < 250; k++) begin
      logic [7:0] ins;
      logic       z;
      int w, op, s3, s5, e_pc, e_cyc, e_reg, e_mr, e_mw;
      ins = 8'($urandom);
      if (ins[7:5] == 3'b111 && $urandom_range(0, 9) != 0) ins[7:5] = 3'b000;
      z = 1'($urandom);
      w = $urandom_range(1, 4);
      op = int'(ins[7:5]);
      s3 = ins[2] ? int'(ins[2:0]) - 8 : int'(ins[2:0]);
      s5 = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
      e_reg = 0; e_mr = 0; e_mw = 0;
      case (op)
        0, 1, 2: begin e_pc = m_pc + 1; e_cyc = 4; e_reg = 1; end
        3:       begin e_pc = m_pc + 1; e_cyc = 4 + w; e_reg = 1; e_mr = w; end
        4:       begin e_pc = m_pc + 1; e_cyc = 3 + w; e_mw = w; end
        5:       begin e_pc = z ? m_pc + 1 + s3 : m_pc + 1; e_cyc = 3; end
        6:       begin e_pc = m_pc + 1 + s5; e_cyc = 3; end
        default: begin e_pc = m_pc; e_cyc = 3; end
      endcase
      e_pc = ((e_pc % 256) + 256) % 256;
      exec_and_check($sformatf("rnd%0d op%0d", k, op), ins, z, w, e_pc, e_cyc, e_reg,
                     e_mr, e_mw, (op == 2) ? 2 : 0, (op == 7) ? 1 : 0);
      if (op == 7) begin
        do_reset();
        check($sformatf("rnd%0d reset pc", k), int'(pc), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
